// File: rtl/hbus_xfer.sv
// HyperBus burst sequencer: command/address phase, initial latency, data streaming toward a DDR pad block.
// Optional macro HBUS_DOUBLE_LATENCY_EN selects fixed double initial latency (2*LATENCY clocks).
module hbus_xfer #(
  parameter int LATENCY  = 6,
  parameter int RD_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        cs_n,
  output logic        ck_en,
  output logic        oe,
  output logic        rwds_o,
  output logic [15:0] dq_out,
  input  logic [15:0] dq_in
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CA   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

`ifdef HBUS_DOUBLE_LATENCY_EN
  localparam int LAT_CYC = 2 * LATENCY;
`else
  localparam int LAT_CYC = LATENCY;
`endif
  localparam logic [3:0] LAT_LOAD = 4'(LAT_CYC - 1);

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] ca_word(input logic we, input logic [31:0] a, input logic [1:0] idx);
    logic [47:0] ca;
    ca = {~we, 1'b0, 1'b1, a[31:3], 13'd0, a[2:0]};
    case (idx)
      2'd0:    return ca[47:32];
      2'd1:    return ca[31:16];
      default: return ca[15:0];
    endcase
  endfunction

  logic [2:0]          state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [3:0]          lat_q, lat_d;
  logic [RD_DELAY-1:0] pipe_q, pipe_d, last_q, last_d;
  logic                cs_n_q, cs_n_d, oe_q, oe_d, ck_q, ck_d;
  logic [15:0]         dq_q, dq_d, rdata_q, rdata_d;
  logic                rv_q, rv_d, done_q, done_d, rdy_q, rdy_d;
  logic                wr_fire, rd_push, emerge, emerge_last;

  assign wr_fire     = (state_q == S_WR) && wdata_valid;
  assign rd_push     = (state_q == S_RD);
  assign emerge      = pipe_q[RD_DELAY-1];
  assign emerge_last = last_q[RD_DELAY-1];

  // Next-state and sequencing counters
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_CA;
          we_d    = req_we;
          addr_d  = req_addr;
          cnt_d   = (req_len == 8'd0) ? 8'd1 : req_len;
          idx_d   = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CA: begin
        if (idx_q == 2'd2) begin
          state_d = S_LAT;
          lat_d   = LAT_LOAD;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_LAT: begin
        if (lat_q == 4'd0) begin
          state_d = we_q ? S_WR : S_RD;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_WR: begin
        if (wr_fire && (cnt_q == 8'd1)) begin
          state_d = S_END;
        end else if (wr_fire) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RD: begin
        if (cnt_q == 8'd1) begin
          state_d = S_END;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_END: begin
        if (we_q || emerge_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_END;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered pad/control outputs derived from the upcoming state
  always_comb begin
    cs_n_d  = !((state_d == S_CA) || (state_d == S_LAT) || (state_d == S_WR) || (state_d == S_RD));
    oe_d    = (state_d == S_CA);
    ck_d    = (state_d == S_CA) || (state_d == S_LAT) || (state_d == S_RD);
    dq_d    = (state_d == S_CA) ? swap16(ca_word(we_d, addr_d, idx_d)) : 16'd0;
    rdy_d   = (state_d == S_IDLE);
    pipe_d  = RD_DELAY'({pipe_q, rd_push});
    last_d  = RD_DELAY'({last_q, rd_push && (cnt_q == 8'd1)});
    rv_d    = emerge;
    rdata_d = emerge ? swap16(dq_in) : rdata_q;
    done_d  = ((state_q == S_WR) && (state_d == S_END)) || emerge_last;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      lat_q   <= 4'd0;
      pipe_q  <= '0;
      last_q  <= '0;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      ck_q    <= 1'b0;
      dq_q    <= 16'd0;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      pipe_q  <= pipe_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      oe_q    <= oe_d;
      ck_q    <= ck_d;
      dq_q    <= dq_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Write words pass straight through so a stalled cycle never clocks the bus
  assign wdata_ready = wr_fire;
  assign oe          = oe_q | wr_fire;
  assign ck_en       = ck_q | wr_fire;
  assign dq_out      = wr_fire ? swap16(wdata) : dq_q;
  assign cs_n        = cs_n_q;
  assign req_ready   = rdy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign done        = done_q;
  assign rwds_o      = 1'b0;

endmodule
